addrmode_seq: RTL

ADDRMODE_SEQ -- requirements
Module: addrmode_seq

---
 rtl/addrmode_seq.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/addrmode_seq.sv
// addrmode_seq: resolves one 6502-style operand addressing mode into an
// effective address by issuing 0..4 single-byte memory reads.
// Optional feature macro: ADDRSEQ_JMPIND_BUG_EN. When it is defined, the
// indirect-absolute (INDY) target high byte is fetched without carry into the
// pointer high byte (NMOS page-wrap quirk).
//
// Handshake: start is sampled only on an edge where busy=0. The request is
// accepted on that edge and busy rises for the following cycle. start seen
// while busy=1 is dropped, not queued. ea_valid pulses for one cycle, with ea,
// pc_adv and err valid alongside it. busy stays high through that cycle and
// falls afterwards. Memory reads: rd/addr are held for one cycle, and data_in
// carries that byte in the next cycle.
module addrmode_seq #(
  parameter logic [7:0] ZP_BASE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  addmod,
  input  logic [15:0] pc,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [7:0]  data_in,
  output logic [15:0] addr,
  output logic        rd,
  output logic [15:0] ea,
  output logic        ea_valid,
  output logic [1:0]  pc_adv,
  output logic        busy,
  output logic        err,
  output logic [2:0]  dbg_state
);

  localparam logic [3:0] M_IXID = 4'd1;
  localparam logic [3:0] M_ZP   = 4'd2;
  localparam logic [3:0] M_IMM  = 4'd3;
  localparam logic [3:0] M_ABS  = 4'd4;
  localparam logic [3:0] M_INDY = 4'd5;
  localparam logic [3:0] M_IDIX = 4'd6;
  localparam logic [3:0] M_ZPX  = 4'd7;
  localparam logic [3:0] M_ZPY  = 4'd8;
  localparam logic [3:0] M_ABSX = 4'd9;
  localparam logic [3:0] M_ABSY = 4'd10;
  localparam logic [3:0] M_ACC  = 4'd11;
  localparam logic [3:0] M_REL  = 4'd12;
  localparam logic [3:0] M_IMP  = 4'd13;

  // Read states name the byte whose read is being driven in that cycle.
  // DONE is the cycle in which the last byte sits on data_in. The result is
  // registered on the DONE->IDLE edge.
  typedef enum logic [2:0] {IDLE, OPLO, OPHI, PTRLO, PTRHI, DONE} state_t;

  state_t      state_q;
  state_t      pend_q;     // which read's byte is on data_in this cycle
  logic [3:0]  mode_q;
  logic [15:0] pc_q;
  logic [7:0]  x_q, y_q;
  logic [7:0]  op_lo_q, op_hi_q, tlo_q;
  logic [15:0] ea_q;
  logic        ea_valid_q;
  logic [1:0]  pc_adv_q;
  logic        busy_q;
  logic        err_q;

  function automatic state_t first_state(input logic [3:0] m);
    case (m)
      M_IXID, M_ZP, M_ABS, M_INDY, M_IDIX,
      M_ZPX, M_ZPY, M_ABSX, M_ABSY, M_REL: first_state = OPLO;
      default:                             first_state = DONE;
    endcase
  endfunction

  function automatic state_t after_read(input state_t s, input logic [3:0] m);
    after_read = DONE;
    case (s)
      OPLO: begin
        if (m == M_ABS || m == M_ABSX || m == M_ABSY || m == M_INDY)
          after_read = OPHI;
        else if (m == M_IXID || m == M_IDIX)
          after_read = PTRLO;
      end
      OPHI:    if (m == M_INDY) after_read = PTRLO;
      PTRLO:   after_read = PTRHI;
      default: after_read = DONE;
    endcase
  endfunction

  // A pointer byte may still be on data_in when the dependent read must be
  // driven. Take the live byte in that cycle, and the captured copy afterwards.
  logic [7:0]  b_live, hi_live, zp_ptr, zp_ptr_inc;
  logic [15:0] ind_ptr, ind_ptr_hi, pc_inc;

  assign b_live     = (pend_q == OPLO) ? data_in : op_lo_q;
  assign hi_live    = (pend_q == OPHI) ? data_in : op_hi_q;
  assign zp_ptr     = (mode_q == M_IXID) ? (b_live + x_q) : b_live;
  assign zp_ptr_inc = zp_ptr + 8'd1;
  assign ind_ptr    = {hi_live, b_live};
  assign pc_inc     = pc_q + 16'd1;

  logic [7:0] ind_lo_inc;
  assign ind_lo_inc = b_live + 8'd1;
`ifdef ADDRSEQ_JMPIND_BUG_EN
  assign ind_ptr_hi = {hi_live, ind_lo_inc};
`else
  assign ind_ptr_hi = ind_ptr + 16'd1;
`endif

  // Read strobe and address follow the current read state.
  always_comb begin
    addr = 16'h0000;
    rd   = 1'b0;
    case (state_q)
      OPLO: begin
        rd   = 1'b1;
        addr = pc_q;
      end
      OPHI: begin
        rd   = 1'b1;
        addr = pc_inc;
      end
      PTRLO: begin
        rd   = 1'b1;
        addr = (mode_q == M_INDY) ? ind_ptr : {ZP_BASE, zp_ptr};
      end
      PTRHI: begin
        rd   = 1'b1;
        addr = (mode_q == M_INDY) ? ind_ptr_hi : {ZP_BASE, zp_ptr_inc};
      end
      default: begin
        rd   = 1'b0;
        addr = 16'h0000;
      end
    endcase
  end

  // In DONE the last byte is on data_in. Form the result from it and from the
  // bytes captured earlier.
  logic [7:0]  zp_x, zp_y;
  logic [15:0] word_op, word_tgt, rel_tgt;
  logic [15:0] ea_d;
  logic [1:0]  pc_adv_d;
  logic        err_d;

  assign zp_x     = data_in + x_q;
  assign zp_y     = data_in + y_q;
  assign word_op  = {data_in, op_lo_q};
  assign word_tgt = {data_in, tlo_q};
  assign rel_tgt  = pc_inc + {{8{data_in[7]}}, data_in};

  // Result of the operand resolution by mode.
  always_comb begin
    ea_d     = 16'h0000;
    pc_adv_d = 2'd0;
    err_d    = 1'b0;
    case (mode_q)
      M_IMM:  begin ea_d = pc_q;                      pc_adv_d = 2'd1; end
      M_ZP:   begin ea_d = {ZP_BASE, data_in};        pc_adv_d = 2'd1; end
      M_ZPX:  begin ea_d = {ZP_BASE, zp_x};           pc_adv_d = 2'd1; end
      M_ZPY:  begin ea_d = {ZP_BASE, zp_y};           pc_adv_d = 2'd1; end
      M_REL:  begin ea_d = rel_tgt;                   pc_adv_d = 2'd1; end
      M_ABS:  begin ea_d = word_op;                   pc_adv_d = 2'd2; end
      M_ABSX: begin ea_d = word_op + {8'h00, x_q};    pc_adv_d = 2'd2; end
      M_ABSY: begin ea_d = word_op + {8'h00, y_q};    pc_adv_d = 2'd2; end
      M_IXID: begin ea_d = word_tgt;                  pc_adv_d = 2'd1; end
      M_IDIX: begin ea_d = word_tgt + {8'h00, y_q};   pc_adv_d = 2'd1; end
      M_INDY: begin ea_d = word_tgt;                  pc_adv_d = 2'd2; end
      M_ACC, M_IMP: begin ea_d = 16'h0000;            pc_adv_d = 2'd0; end
      default: err_d = 1'b1;
    endcase
  end

  // Sequencer: accepts a request, steps through the reads, captures returning
  // bytes, and registers the one-cycle result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= IDLE;
      mode_q     <= 4'd0;
      pc_q       <= 16'h0000;
      x_q        <= 8'h00;
      y_q        <= 8'h00;
      op_lo_q    <= 8'h00;
      op_hi_q    <= 8'h00;
      tlo_q      <= 8'h00;
      ea_q       <= 16'h0000;
      ea_valid_q <= 1'b0;
      pc_adv_q   <= 2'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pend_q <= rd ? state_q : IDLE;
      case (pend_q)
        OPLO:    op_lo_q <= data_in;
        OPHI:    op_hi_q <= data_in;
        PTRLO:   tlo_q   <= data_in;
        default: ;
      endcase
      case (state_q)
        IDLE: begin
          ea_valid_q <= 1'b0;
          ea_q       <= 16'h0000;
          pc_adv_q   <= 2'd0;
          err_q      <= 1'b0;
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            mode_q  <= addmod;
            pc_q    <= pc;
            x_q     <= x;
            y_q     <= y;
            busy_q  <= 1'b1;
            state_q <= first_state(addmod);
          end
        end
        OPLO, OPHI, PTRLO, PTRHI: state_q <= after_read(state_q, mode_q);
        DONE: begin
          state_q    <= IDLE;
          ea_valid_q <= 1'b1;
          ea_q       <= ea_d;
          pc_adv_q   <= pc_adv_d;
          err_q      <= err_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ea        = ea_q;
  assign ea_valid  = ea_valid_q;
  assign pc_adv    = pc_adv_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
